// File: rtl/pipe_pkg.sv
// pipe_chain shared package
// Occupancy width helper and identity mask defaults
package pipe_pkg;

  localparam logic [63:0] MASK_ONES  = '1;
  localparam logic [63:0] MASK_ZEROS = '0;

  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_chain_if.sv
// pipe_chain handshake bundle
// Upstream valid/ready/data and downstream valid/ready/data
interface pipe_chain_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );

endinterface

// File: rtl/pipe_stage.sv
// One pipeline slot: valid bit plus data word
// clr drops the word, load takes the upstream slot
module pipe_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_clr,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // slot register: reset clears all, clr only the valid bit
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_clr) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= i_valid;
      r_data  <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/pipe_chain.sv
// Back-pressured register pipeline with stage-0 mask
// Ready chain, warm-up gate, flush and occupancy count
module pipe_chain
  import pipe_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter int               DEPTH    = 3,
  parameter logic [WIDTH-1:0] AND_MASK = MASK_ONES[WIDTH-1:0],
  parameter logic [WIDTH-1:0] OR_MASK  = MASK_ZEROS[WIDTH-1:0]
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  pipe_chain_if.slave                  bus,
  output logic [occ_width(DEPTH)-1:0]  occupancy,
  output logic                         busy
);

  localparam int OW = occ_width(DEPTH);

  logic             r_en;
  logic [OW-1:0]    r_occ;
  logic [DEPTH-1:0] w_valid;
  logic [DEPTH-1:0] w_rdy;
  logic [DEPTH-1:0] w_vin;
  logic [WIDTH-1:0] w_data [DEPTH];
  logic [WIDTH-1:0] w_din  [DEPTH];
  logic             w_in_acc;
  logic             w_out_acc;

  // ready ripples back from the output; empty slots always accept
  always_comb begin
    w_rdy = '0;
    w_rdy[DEPTH-1] = ~w_valid[DEPTH-1] | bus.out_ready;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      w_rdy[i] = ~w_valid[i] | w_rdy[i+1];
    end
  end

  assign bus.in_ready  = w_rdy[0] & r_en & ~flush;
  assign w_in_acc      = bus.in_valid & bus.in_ready;
  assign bus.out_valid = w_valid[DEPTH-1];
  assign bus.out_data  = w_data[DEPTH-1];
  assign w_out_acc     = bus.out_valid & bus.out_ready;

  // slot inputs: masked word into slot 0, shift from the previous slot
  always_comb begin
    w_vin    = '0;
    w_vin[0] = w_in_acc;
    w_din[0] = (bus.in_data & AND_MASK) | OR_MASK;
    for (int i = 1; i < DEPTH; i++) begin
      w_vin[i] = w_valid[i-1];
      w_din[i] = w_data[i-1];
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    pipe_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk     (clk),
      .reset   (reset),
      .i_load  (w_rdy[g]),
      .i_clr   (flush),
      .i_valid (w_vin[g]),
      .i_data  (w_din[g]),
      .o_valid (w_valid[g]),
      .o_data  (w_data[g])
    );
  end

  // warm-up: block input for the first cycle after reset
  always_ff @(posedge clk) begin
    if (reset) r_en <= 1'b0;
    else       r_en <= 1'b1;
  end

  // occupancy tracks accepted minus delivered words
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_occ <= '0;
    end else if (w_in_acc && !w_out_acc) begin
      r_occ <= r_occ + OW'(1);
    end else if (!w_in_acc && w_out_acc) begin
      r_occ <= r_occ - OW'(1);
    end
  end

  assign occupancy = r_occ;
  assign busy      = (r_occ != '0);

endmodule

// File: tb/tb_pipe_chain.sv
// pipe_chain testbench
// Directed plus random steps against a slot-position model
module tb_pipe_chain;
  import pipe_pkg::*;

  localparam int W  = 8;
  localparam int D  = 3;
  localparam int OW = occ_width(D);

  logic clk = 1'b0;
  logic reset;
  logic flush;
  logic m_flush;
  logic [OW-1:0] occ;
  logic [OW-1:0] m_occ;
  logic busy;
  logic m_busy;

  always #5 clk = ~clk;

  pipe_chain_if #(.WIDTH(W)) bus ();
  pipe_chain_if #(.WIDTH(W)) mbus ();

  pipe_chain #(
    .WIDTH (W),
    .DEPTH (D)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .bus       (bus),
    .occupancy (occ),
    .busy      (busy)
  );

  pipe_chain #(
    .WIDTH    (W),
    .DEPTH    (D),
    .AND_MASK (8'hF0),
    .OR_MASK  (8'h01)
  ) dut_m (
    .clk       (clk),
    .reset     (reset),
    .flush     (m_flush),
    .bus       (mbus),
    .occupancy (m_occ),
    .busy      (m_busy)
  );

  int total = 0;
  int bad   = 0;

  // model: words in order with their slot position 0..D-1
  bit         m_en;
  logic [W-1:0] q_d[$];
  int           q_p[$];

  // observations from the latest step
  logic         o_ir;
  logic         o_ov;
  logic [W-1:0] o_od;
  bit           last_acc;
  bit           last_oacc;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit rs, input bit fl, input bit iv,
                      input logic [W-1:0] id, input bit ordy);
    bit m_ir;
    bit m_ov;
    int lim;
    @(negedge clk);
    reset         = rs;
    flush         = fl;
    bus.in_valid  = iv;
    bus.in_data   = id;
    bus.out_ready = ordy;
    #1;
    m_ir = m_en && !fl && (q_d.size() < D || ordy);
    m_ov = (q_d.size() > 0) && (q_p[0] == D - 1);
    o_ir = bus.in_ready;
    o_ov = bus.out_valid;
    o_od = bus.out_data;
    chk("in_ready", bus.in_ready, m_ir);
    chk("out_valid", bus.out_valid, m_ov);
    if (m_ov) chk("out_data", bus.out_data, q_d[0]);
    chk("occupancy", occ, q_d.size());
    chk("busy", busy, q_d.size() != 0);
    chk("occ_bound", occ <= D, 1);
    last_acc  = iv && m_ir;
    last_oacc = m_ov && ordy;
    @(posedge clk);
    if (rs) begin
      q_d.delete();
      q_p.delete();
      m_en = 0;
    end else begin
      m_en = 1;
      if (last_oacc) begin
        void'(q_d.pop_front());
        void'(q_p.pop_front());
      end
      if (fl) begin
        q_d.delete();
        q_p.delete();
      end else begin
        for (int k = 0; k < q_p.size(); k++) begin
          lim = (k == 0) ? D - 1 : q_p[k-1] - 1;
          if (q_p[k] < lim) q_p[k] = q_p[k] + 1;
        end
        if (last_acc) begin
          q_d.push_back(id);
          q_p.push_back(0);
        end
      end
    end
  endtask

  initial begin
    int n;
    bit got;
    reset          = 1'b1;
    flush          = 1'b0;
    m_flush        = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.out_ready  = 1'b0;
    mbus.in_valid  = 1'b0;
    mbus.in_data   = '0;
    mbus.out_ready = 1'b0;
    m_en           = 0;
    repeat (2) @(posedge clk);

    // reset values and warm-up
    step(1, 0, 0, 8'h00, 1);
    #2 chk("rst_out_data", bus.out_data, 8'h00);
    step(0, 0, 1, 8'hA5, 1);
    chk("warmup_block", o_ir, 1'b0);
    step(0, 0, 1, 8'hA6, 1);
    chk("first_accept", last_acc, 1'b1);
    step(0, 0, 0, 8'h00, 1);
    step(0, 0, 0, 8'h00, 1);
    step(0, 0, 0, 8'h00, 1);
    chk("latency_valid", o_ov, 1'b1);
    chk("latency_data", o_od, 8'hA6);

    // streaming 0x01..0x10
    for (int v = 1; v <= 16; v++) step(0, 0, 1, W'(v), 1);
    chk("stream_occ", occ, 3);
    repeat (4) step(0, 0, 0, 8'h00, 1);

    // backpressure
    n = 0;
    for (int c = 0; c < 6; c++) begin
      step(0, 0, 1, W'($urandom), 0);
      if (last_acc) n++;
    end
    chk("stall_accepts", n, 3);
    step(0, 0, 1, 8'h77, 1);
    chk("freed_slot", o_ir, 1'b1);
    repeat (5) step(0, 0, 0, 8'h00, 1);

    // flush with two words in flight and output handshake
    step(0, 0, 1, 8'h11, 0);
    step(0, 0, 1, 8'h22, 0);
    step(0, 0, 0, 8'h00, 0);
    step(0, 1, 0, 8'h00, 1);
    chk("flush_handshake", last_oacc, 1'b1);
    chk("flush_word", o_od, 8'h11);
    step(0, 0, 0, 8'h00, 1);
    chk("flush_ov", o_ov, 1'b0);
    repeat (4) step(0, 0, 0, 8'h00, 1);

    // random traffic
    for (int c = 0; c < 400; c++) begin
      step(0, ($urandom_range(0, 19) == 0), $urandom_range(0, 1),
           W'($urandom), ($urandom_range(0, 3) != 0));
    end

    // mid-stream reset with a full pipeline
    repeat (5) step(0, 0, 1, W'($urandom), 0);
    chk("full_occ", occ, 3);
    step(1, 0, 1, 8'h5A, 0);
    step(0, 0, 1, 8'h5B, 1);
    chk("post_rst_occ", occ, 0);
    chk("post_rst_od", o_od, 8'h00);
    chk("post_rst_warm", o_ir, 1'b0);
    step(0, 0, 1, 8'h5C, 1);
    chk("post_rst_ready", o_ir, 1'b1);
    step(0, 0, 0, 8'h00, 1);
    chk("restart_occ", occ, 1);
    repeat (4) step(0, 0, 0, 8'h00, 1);

    // mask instance: 0x3C -> 0x31
    @(negedge clk);
    mbus.in_valid  = 1'b1;
    mbus.in_data   = 8'h3C;
    mbus.out_ready = 1'b1;
    #1 chk("mask_in_ready", mbus.in_ready, 1'b1);
    @(negedge clk);
    mbus.in_valid = 1'b0;
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      #1;
      if (mbus.out_valid) got = 1;
      else @(negedge clk);
    end
    chk("mask_seen", got, 1'b1);
    chk("mask_data", mbus.out_data, 8'h31);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
